// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared constants, record layout and serializer state
//               encoding for the commit-trace capture unit.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

  localparam logic [7:0] TRACE_SYNC = 8'hA5;
  localparam int         REC_BYTES  = 14;
  // pc + inst + wb byte + wdata; the sync byte is added by the serializer
  localparam int         REC_W      = 104;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wb_flag;
    logic [1:0]  pad;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } trace_rec_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Single-clock record FIFO. Pointers carry one extra MSB so
//               full and empty are told apart without a separate counter.
// Ports       : clk_in, reset (async active-low), push/wdata, pop/rdata
//               (first-word fall-through), full, empty.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = REC_W
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: resetting the pointers discards the contents.
  always_ff @(posedge clk_in) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule : trace_fifo
`default_nettype wire

// File: rtl/commit_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_capture
// Description : Builds one trace record per retired instruction from the
//               core's pc/inst and register-file write port, buffers the
//               records and streams them as 14-byte packets over valid/ready.
// Ports       : clk_in, reset (async active-low), trace_en,
//               pc, inst, rf_we, rf_waddr, rf_wdata   - core observation
//               tx_data, tx_valid, tx_ready             - byte stream
//               overflow, drop_cnt                      - drop statistics
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_capture
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              trace_en,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [31:0]       rf_wdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  // ---------------- tracker ----------------
  logic        cur_valid;
  logic [31:0] cur_pc;
  logic [31:0] cur_inst;
  logic        wb_flag;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        wr_hit;
  logic        retire;
  trace_rec_t  rec_new;

  assign wr_hit = rf_we && (rf_waddr != 5'd0);
  assign retire = cur_valid && (pc != cur_pc);

  // A write on the retire edge still belongs to the retiring instruction,
  // and it is the latest write, so it overrides the stored one.
  always_comb begin
    rec_new         = '0;
    rec_new.pc      = cur_pc;
    rec_new.inst    = cur_inst;
    rec_new.wb_flag = wb_flag || wr_hit;
    if (wr_hit) begin
      rec_new.wb_addr = rf_waddr;
      rec_new.wb_data = rf_wdata;
    end else if (wb_flag) begin
      rec_new.wb_addr = wb_addr;
      rec_new.wb_data = wb_data;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cur_valid <= 1'b0;
      cur_pc    <= '0;
      cur_inst  <= '0;
      wb_flag   <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      if (!cur_valid || retire) begin
        cur_valid <= 1'b1;
        cur_pc    <= pc;
        cur_inst  <= inst;
      end
      if (retire) begin
        wb_flag <= 1'b0;
        wb_addr <= '0;
        wb_data <= '0;
      end else if (wr_hit) begin
        wb_flag <= 1'b1;
        wb_addr <= rf_waddr;
        wb_data <= rf_wdata;
      end
    end
  end

  // ---------------- FIFO and drop accounting ----------------
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic             drop;
  logic [REC_W-1:0] fifo_rdata;

  // full is sampled before this edge's pop, so a pop never makes room
  // for a push on the same edge.
  assign fifo_push = retire && trace_en && !fifo_full;
  assign drop      = retire && trace_en &&  fifo_full;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (fifo_push),
    .wdata  (rec_new),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // ---------------- serializer ----------------
  ser_state_t               state;
  ser_state_t               state_nx;
  logic [3:0]               idx;
  logic [REC_BYTES*8-1:0]   shreg;
  logic                     accept;
  logic                     last;

  assign tx_valid = (state == SEND);
  assign tx_data  = shreg[REC_BYTES*8-1 -: 8];
  assign accept   = tx_valid && tx_ready;
  assign last     = accept && (idx == 4'(REC_BYTES-1));

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (last) begin
          if (!fifo_empty) fifo_pop = 1'b1;  // chain records with no gap
          else             state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shifting zeros in leaves tx_data at 0 once a record is fully sent.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      idx   <= '0;
    end else if (fifo_pop) begin
      shreg <= {TRACE_SYNC, fifo_rdata};
      idx   <= '0;
    end else if (accept) begin
      shreg <= {shreg[REC_BYTES*8-9:0], 8'h00};
      idx   <= idx + 4'd1;
    end
  end

endmodule : commit_trace_capture
`default_nettype wire

// File: tb/tb_commit_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_capture
// Description : Self-checking bench: directed record table, stall, overflow,
//               saturation, random traffic and mid-record reset, checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_capture;

  localparam int DEPTH = 2;
  localparam int DW    = 4;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          trace_en;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          overflow;
  logic [DW-1:0] drop_cnt;

  commit_trace_capture #(.FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .trace_en (trace_en),
    .pc       (pc),
    .inst     (inst),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // bytes actually accepted from the DUT
  logic [7:0] rx_q[$];
  always @(posedge clk_in) begin
    if (reset && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  // ---------------- reference model ----------------
  logic [111:0] m_fifo[$];
  logic [111:0] m_sh;
  int           m_idx;
  bit           m_send;
  bit           m_cv;
  logic [31:0]  m_pc, m_inst;
  bit           m_wf;
  logic [4:0]   m_wa;
  logic [31:0]  m_wd;
  int           m_drop;
  bit           m_ovf;
  logic [7:0]   m_rx[$];

  task automatic m_reset();
    m_fifo.delete();
    m_sh = '0; m_idx = 0; m_send = 0; m_cv = 0;
    m_pc = '0; m_inst = '0; m_wf = 0; m_wa = '0; m_wd = '0;
    m_drop = 0; m_ovf = 0;
  endtask

  function automatic logic [7:0] m_byte();
    return m_send ? m_sh[111-8*m_idx -: 8] : 8'h00;
  endfunction

  // one clock edge, using the inputs currently applied
  task automatic model_edge();
    bit           acc, hit, ret, was_full, pop_now, flag;
    logic [4:0]   a;
    logic [31:0]  d;
    acc      = m_send && tx_ready;
    hit      = rf_we && (rf_waddr != 0);
    ret      = m_cv && (pc != m_pc);
    was_full = (m_fifo.size() >= DEPTH);
    pop_now  = (m_fifo.size() > 0) && (!m_send || (acc && m_idx == 13));
    if (acc) begin
      m_rx.push_back(m_byte());
      m_idx++;
      if (m_idx == 14) m_send = 0;
    end
    if (pop_now) begin
      m_sh = m_fifo.pop_front(); m_idx = 0; m_send = 1;
    end
    if (ret && trace_en) begin
      flag = m_wf || hit;
      a = hit ? rf_waddr : m_wa;
      d = hit ? rf_wdata : m_wd;
      if (!flag) begin a = '0; d = '0; end
      if (was_full) begin
        m_ovf = 1;
        if (m_drop < (1 << DW) - 1) m_drop++;
      end else begin
        m_fifo.push_back({8'hA5, m_pc, m_inst, flag, 2'b00, a, d});
      end
    end
    if (!m_cv || ret) begin m_cv = 1; m_pc = pc; m_inst = inst; end
    if (ret) begin m_wf = 0; m_wa = '0; m_wd = '0; end
    else if (hit) begin m_wf = 1; m_wa = rf_waddr; m_wd = rf_wdata; end
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // check outputs mid-cycle, advance the model, take the edge
  task automatic cycle();
    @(negedge clk_in);
    chk("cycle", {tx_valid, tx_data, overflow, drop_cnt},
        {m_send, m_byte(), m_ovf, 4'(m_drop)});
    model_edge();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_in(logic [31:0] p, logic [31:0] i, logic we,
                        logic [4:0] wa, logic [31:0] wd);
    pc = p; inst = i; rf_we = we; rf_waddr = wa; rf_wdata = wd;
  endtask

  task automatic cmp_streams(string name);
    int first;
    first = -1;
    for (int k = 0; k < rx_q.size() && k < m_rx.size(); k++)
      if (first < 0 && rx_q[k] !== m_rx[k]) first = k;
    tests++;
    if (rx_q.size() != m_rx.size() || first >= 0) begin
      fails++;
      $display("FAIL %s: got %0d bytes, expected %0d, first differing index %0d",
               name, rx_q.size(), m_rx.size(), first);
    end
  endtask

  function automatic logic [111:0] rx_rec(int base);
    logic [111:0] r;
    r = '0;
    for (int k = 0; k < 14; k++) r = {r[103:0], rx_q[base+k]};
    return r;
  endfunction

  // ---------------- directed record table ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          late;   // write presented on the retire edge
    logic [7:0]  b9;
    logic [31:0] ewd;
  } vec_t;

  vec_t tab[5];

  initial begin
    logic [7:0]  held;
    int          base, guard;
    bit          prev_late;
    logic [4:0]  prev_wa;
    logic [31:0] prev_wd;
    logic [31:0] p;

    tab[0] = '{32'h0040_0000, 32'h2408_0005, 1, 5'd8, 32'h0000_0005, 0, 8'h88, 32'h0000_0005};
    tab[1] = '{32'h0040_0004, 32'h2408_0005, 0, 5'd0, 32'h0,         0, 8'h00, 32'h0};
    tab[2] = '{32'h0040_0008, 32'h2400_0007, 1, 5'd0, 32'hDEAD_BEEF, 0, 8'h00, 32'h0};
    tab[3] = '{32'h0040_000C, 32'h8C09_0010, 1, 5'd9, 32'h0000_1234, 1, 8'h89, 32'h0000_1234};
    tab[4] = '{32'h0040_0010, 32'h0000_0000, 0, 5'd0, 32'h0,         0, 8'h00, 32'h0};

    reset = 1'b0; trace_en = 1'b1; tx_ready = 1'b1;
    set_in(32'h0040_0000, 32'h2408_0005, 0, 0, 0);
    m_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_values", {tx_valid, tx_data, overflow, drop_cnt}, 14'd0);
    reset = 1'b1;

    // ---- table phase: 16 cycles per instruction ----
    prev_late = 0; prev_wa = 0; prev_wd = 0;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 16; c++) begin
        set_in(tab[i].pc, tab[i].inst, 0, 0, 0);
        if (c == 0 && prev_late) begin
          rf_we = 1; rf_waddr = prev_wa; rf_wdata = prev_wd;
        end else if (c == 5 && tab[i].we && !tab[i].late) begin
          rf_we = 1; rf_waddr = tab[i].wa; rf_wdata = tab[i].wd;
        end
        cycle();
      end
      prev_late = tab[i].we && tab[i].late;
      prev_wa = tab[i].wa; prev_wd = tab[i].wd;
    end
    for (int c = 0; c < 36; c++) begin
      set_in(32'h0040_0014, 32'h0, (c == 0) && prev_late, prev_wa, prev_wd);
      cycle();
    end
    chk("table_count", rx_q.size(), 70);
    if (rx_q.size() == 70)
      for (int i = 0; i < 5; i++)
        chk($sformatf("table_rec%0d", i), rx_rec(14*i),
            {8'hA5, tab[i].pc, tab[i].inst, tab[i].b9, tab[i].ewd});
    cmp_streams("stream_table");

    // ---- stall mid-record ----
    set_in(32'h0040_0020, 32'h1111_2222, 0, 0, 0);
    repeat (5) cycle();
    tx_ready = 0;
    held = m_byte();
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (c == 19) chk("stall_hold", tx_data, held);
    end
    tx_ready = 1;
    repeat (20) cycle();
    cmp_streams("stream_stall");

    // ---- overflow: one record stalled in flight, then 5 retires ----
    tx_ready = 0;
    set_in(32'h0000_0100, 32'h3333_0000, 0, 0, 0);
    repeat (3) cycle();
    for (int r = 1; r <= 5; r++) begin
      set_in(32'h0000_0100 + 4*r, 32'h3333_0000 + r, 1, 5'(r), 32'h100 + r);
      repeat (2) cycle();
    end
    rf_we = 0;
    chk("ovf_drop_cnt", drop_cnt, 4'd3);
    chk("ovf_flag", overflow, 1'b1);
    base = rx_q.size();
    tx_ready = 1;
    repeat (60) cycle();
    chk("ovf_drain_bytes", rx_q.size() - base, 42);
    cmp_streams("stream_ovf");

    // ---- saturation ----
    tx_ready = 0;
    for (int r = 0; r < 20; r++) begin
      set_in(32'h0000_0200 + 4*r, 32'h4444_0000 + r, 0, 0, 0);
      cycle();
    end
    chk("drop_saturate", drop_cnt, 4'hF);
    tx_ready = 1;
    repeat (40) cycle();

    // ---- random traffic ----
    p = 32'h0001_0000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 15) p = p + 4 * $urandom_range(1, 4);
      set_in(p, $urandom, ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)), $urandom);
      trace_en = ($urandom_range(0, 99) < 90);
      tx_ready = (n < 700) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 90);
      cycle();
    end
    trace_en = 1; tx_ready = 1; rf_we = 0;
    repeat (60) cycle();
    cmp_streams("stream_random");

    // ---- reset during byte 7 ----
    set_in(32'h0002_0000, 32'h5555_5555, 0, 0, 0);
    guard = 0;
    while (!(m_send && m_idx == 7) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("reach_byte7", guard < 100, 1'b1);
    cmp_streams("stream_pre_reset");
    #2;
    reset = 0;
    set_in(32'h0080_0000, 32'h6666_0000, 0, 0, 0);
    #1;
    chk("async_reset", {tx_valid, tx_data, overflow, drop_cnt}, 14'd0);
    rx_q.delete(); m_rx.delete(); m_reset();
    @(posedge clk_in);
    #1;
    reset = 1;
    repeat (4) cycle();
    set_in(32'h0080_0004, 32'h6666_0004, 0, 0, 0);
    repeat (16) cycle();
    set_in(32'h0080_0008, 32'h6666_0008, 0, 0, 0);
    repeat (20) cycle();
    chk("post_reset_count", rx_q.size(), 28);
    if (rx_q.size() == 28) begin
      chk("post_reset_rec0", rx_rec(0),  {8'hA5, 32'h0080_0000, 32'h6666_0000, 8'h00, 32'h0});
      chk("post_reset_rec1", rx_rec(14), {8'hA5, 32'h0080_0004, 32'h6666_0004, 8'h00, 32'h0});
    end
    cmp_streams("stream_post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_commit_trace_capture
`default_nettype wire
